sss_stream_gen: RTL and testbench
=================================

SSS_STREAM_GEN -- requirements
Module: sss_stream_gen

Interface
REQ-001 SHALL have parameter LFSR_W, default 5; LFSR width, sequence length L = 2^LFSR_W - 1 (31).
REQ-002 SHALL have parameter S_TAPS, default 5'b00101; s-sequence recurrence taps.
REQ-003 SHALL have parameter C_TAPS, default 5'b01001; c-sequence recurrence taps.
REQ-004 SHALL have parameter Z_TAPS, default 5'b10111; z-sequence recurrence taps.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1, request generation; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current job.
REQ-009 SHALL have port n_id_2, input, 2, cell identity group member 0..2.
REQ-010 SHALL have port m0, input, LFSR_W, s0 cyclic shift.
REQ-011 SHALL have port m1, input, LFSR_W, s1 cyclic shift.
REQ-012 SHALL have port subframe5, input, 1, 0 = subframe 0 mapping, 1 = subframe 5 mapping.
REQ-013 SHALL have port busy, output, 1, job in progress.
REQ-014 SHALL have port cfg_err, output, 1, one-cycle pulse when start is rejected.
REQ-015 SHALL have port dout, output, 2, {d(2n+1), d(2n)} for beat n.
REQ-016 SHALL have port dout_valid, output, 1, beat valid.
REQ-017 SHALL have port dout_ready, input, 1, downstream accepts beat.
REQ-018 SHALL have port dout_last, output, 1, high with beat n = L-1.
REQ-019 SHALL have port done, output, 1, one-cycle pulse after the last beat transfers.

Function
REQ-020 Base sequences x_s, x_c, x_z: x(0..LFSR_W-2)=0, x(LFSR_W-1)=1; x(i+LFSR_W) = XOR of x(i+k) over all k with TAPS[k]=1; bit 1 represents value -1.
REQ-021 Definitions (indices mod L): s0(n)=x_s(n+m0), s1(n)=x_s(n+m1), c0(n)=x_c(n+n_id_2), c1(n)=x_c(n+n_id_2+3), z0(n)=x_z(n+(m0 mod 8)), z1(n)=x_z(n+(m1 mod 8)).
REQ-022 subframe5=0: d(2n)=s0^c0, d(2n+1)=s1^c1^z0; subframe5=1: d(2n)=s1^c0, d(2n+1)=s0^c1^z1.
REQ-023 States IDLE, GEN, STREAM; reset state IDLE.
REQ-024 IDLE: start=1 with valid config latches n_id_2, m0, m1, subframe5 and moves to GEN; busy=1 from the next cycle.
REQ-025 Valid config: n_id_2<=2, m0<L, m1<L; otherwise start is ignored, state stays IDLE, cfg_err pulses one cycle on the following cycle.
REQ-026 GEN: three LFSRs step once per cycle for exactly L cycles, filling L-bit sequence buffers; then STREAM.
REQ-027 Latency: first dout_valid=1 exactly L+1 clock edges after the edge sampling start.
REQ-028 STREAM: beats n=0..L-1 in order; dout/dout_last held stable while dout_valid=1 and dout_ready=0; n advances only on dout_valid & dout_ready.
REQ-029 Transfer of beat L-1: next cycle state IDLE, busy=0, dout_valid=0, done=1 for one cycle.
REQ-030 start while busy=1 ignored, no cfg_err; latched config unchanged for the whole job.
REQ-031 abort=1 in GEN or STREAM: next cycle IDLE, busy=0, dout_valid=0, no done; abort and start together in IDLE: abort wins, job not started.
REQ-032 dout_ready ignored while dout_valid=0; back-to-back jobs allowed: start may be accepted in the cycle done=1.

Reset
REQ-033 reset_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, cfg_err=0, dout=0, dout_valid=0, dout_last=0, done=0, beat counter 0, buffers and latched config 0.
REQ-034 Reset asserted mid-GEN or mid-STREAM SHALL abandon the job with no done pulse; first start after reset_n release behaves as from power-up.

Verification
REQ-035 Defaults, n_id_2=0, m0=0, m1=1, subframe5=0, dout_ready=1 -> x_s begins 0000100101, 31 beats match software model, dout_last on beat 30, done one cycle later.
REQ-036 Same job, subframe5=1 -> d(2n)/d(2n+1) use swapped s0/s1 and z1 per REQ-022, bit-exact to model.
REQ-037 Random dout_ready (50%) -> no beat lost or repeated, dout stable during stalls, first valid at edge 32 after start.
REQ-038 start with m0=31 or n_id_2=3 -> cfg_err one pulse, busy stays 0, no output.
REQ-039 abort on beat 10, then reset_n low during GEN of a new job -> both return to IDLE, no done, outputs 0.
REQ-040 start held high through a job -> second job begins in the done cycle, first valid L+1 edges later.

Source files
------------

// File: rtl/sss_stream_gen_if.sv
// SSS beat stream: 2-bit beats {d(2n+1), d(2n)} with valid/ready handshake and an end-of-sequence marker.
interface sss_stream_gen_if;
  logic [1:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;

  modport master (output dout, dout_valid, dout_last, input dout_ready);
  modport slave  (input dout, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/sss_stream_gen.sv
// SSS generator: builds the s/c/z m-sequences into buffers with three LFSR lanes,
// then streams the L scrambled 2-bit beats for the latched cell configuration.
module sss_stream_gen #(
  parameter int unsigned       LFSR_W = 5,
  parameter logic [LFSR_W-1:0] S_TAPS = 5'b00101,
  parameter logic [LFSR_W-1:0] C_TAPS = 5'b01001,
  parameter logic [LFSR_W-1:0] Z_TAPS = 5'b10111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        n_id_2,
  input  logic [LFSR_W-1:0] m0,
  input  logic [LFSR_W-1:0] m1,
  input  logic              subframe5,
  output logic              busy,
  output logic              cfg_err,
  output logic              done,
  sss_stream_gen_if.master  dst
);
  localparam int unsigned              L     = (1 << LFSR_W) - 1;
  localparam logic [LFSR_W:0]          L_CNT = {1'b0, {LFSR_W{1'b1}}};
  localparam logic [LFSR_W-1:0]        L_MAX = {{(LFSR_W-1){1'b1}}, 1'b0};
  localparam logic [LFSR_W-1:0]        SEED  = {1'b1, {(LFSR_W-1){1'b0}}};
  localparam logic [2:0][LFSR_W-1:0]   TAPS  = {Z_TAPS, C_TAPS, S_TAPS};

  typedef enum logic [1:0] {IDLE, GEN, STREAM} state_t;
  state_t state, state_nx;

  logic                    cfg_ok, accept, reject, gen_step, gen_end, xfer, abort_job;
  logic [1:0]              nid_q;
  logic [LFSR_W-1:0]       m0_q, m1_q;
  logic                    sf5_q;
  logic [LFSR_W:0]         gen_cnt;
  logic [LFSR_W-1:0]       beat, beat_nx;
  logic [2:0][L-1:0]       seq_buf;
  logic [1:0]              dout_q, dout_nx;
  logic                    valid_q, last_q, done_q, cfg_err_q;
  logic                    s0, s1, c0, c1, z0, z1;

  // (a + b) mod L for a, b < L
  function automatic logic [LFSR_W-1:0] wrap_add(input logic [LFSR_W-1:0] a,
                                                 input logic [LFSR_W-1:0] b);
    logic [LFSR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= L_CNT) s = s - L_CNT;
    return s[LFSR_W-1:0];
  endfunction

  assign cfg_ok    = (n_id_2 <= 2'd2) && (m0 != {LFSR_W{1'b1}}) && (m1 != {LFSR_W{1'b1}});
  assign abort_job = abort && (state != IDLE);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    gen_step = 1'b0;
    gen_end  = 1'b0;
    xfer     = 1'b0;
    unique case (state)
      IDLE:
        if (start && !abort) begin
          if (cfg_ok) begin
            accept   = 1'b1;
            state_nx = GEN;
          end else begin
            reject   = 1'b1;
          end
        end
      GEN:
        if (abort) state_nx = IDLE;
        else if (gen_cnt == L_CNT) begin
          gen_end  = 1'b1;
          state_nx = STREAM;
        end else gen_step = 1'b1;
      STREAM:
        if (abort) state_nx = IDLE;
        else if (valid_q && dst.dout_ready) begin
          xfer = 1'b1;
          if (last_q) state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end

  // One lane per base sequence: LFSR window x(i..i+W-1), bit 0 is x(i)
  for (genvar k = 0; k < 3; k++) begin : g_seq
    logic [LFSR_W-1:0] lfsr;
    logic [L-1:0]      sbuf;

    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        lfsr <= '0;
        sbuf <= '0;
      end else if (accept) begin
        lfsr <= SEED;
        sbuf <= '0;
      end else if (gen_step) begin
        sbuf[gen_cnt[LFSR_W-1:0]] <= lfsr[0];
        lfsr <= {^(lfsr & TAPS[k]), lfsr[LFSR_W-1:1]};
      end

    assign seq_buf[k] = sbuf;
  end

  // Next beat to present: beat 0 on leaving GEN, otherwise the one after the current
  assign beat_nx = gen_end ? '0 : beat + 1'b1;

  always_comb begin
    s0 = seq_buf[0][wrap_add(beat_nx, m0_q)];
    s1 = seq_buf[0][wrap_add(beat_nx, m1_q)];
    c0 = seq_buf[1][wrap_add(beat_nx, LFSR_W'(nid_q))];
    c1 = seq_buf[1][wrap_add(beat_nx, LFSR_W'(nid_q) + LFSR_W'(3))];
    z0 = seq_buf[2][wrap_add(beat_nx, LFSR_W'(m0_q[2:0]))];
    z1 = seq_buf[2][wrap_add(beat_nx, LFSR_W'(m1_q[2:0]))];
    dout_nx = sf5_q ? {s0 ^ c1 ^ z1, s1 ^ c0} : {s1 ^ c1 ^ z0, s0 ^ c0};
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      nid_q     <= '0;
      m0_q      <= '0;
      m1_q      <= '0;
      sf5_q     <= 1'b0;
      gen_cnt   <= '0;
      beat      <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= reject;
      if (accept) begin
        nid_q   <= n_id_2;
        m0_q    <= m0;
        m1_q    <= m1;
        sf5_q   <= subframe5;
        gen_cnt <= '0;
      end
      if (gen_step) gen_cnt <= gen_cnt + 1'b1;
      // Registered output beat; the extra cycle after GEN preloads beat 0
      if (gen_end || (xfer && !last_q)) begin
        beat    <= beat_nx;
        dout_q  <= dout_nx;
        last_q  <= (beat_nx == L_MAX);
        valid_q <= 1'b1;
      end
      if (abort_job || (xfer && last_q)) begin
        beat    <= '0;
        dout_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end
      if (xfer && last_q) done_q <= 1'b1;
    end

  assign busy           = (state != IDLE);
  assign cfg_err        = cfg_err_q;
  assign done           = done_q;
  assign dst.dout       = dout_q;
  assign dst.dout_valid = valid_q;
  assign dst.dout_last  = last_q;
endmodule

// File: tb/tb_sss_stream_gen.sv
// Directed bench for sss_stream_gen: beats against a recurrence model plus hand-computed beats.
module tb_sss_stream_gen;
  localparam int L = 31;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       subframe5 = 1'b0;
  logic [1:0] n_id_2 = 2'd0;
  logic [4:0] m0 = 5'd0;
  logic [4:0] m1 = 5'd0;
  logic       busy, cfg_err, done;
  int         n_run = 0;
  int         n_fail = 0;
  logic [1:0] cap [L];

  sss_stream_gen_if sif();

  sss_stream_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .n_id_2(n_id_2), .m0(m0), .m1(m1), .subframe5(subframe5),
    .busy(busy), .cfg_err(cfg_err), .done(done), .dst(sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] xseq(input logic [4:0] taps);
    logic [30:0] x;
    x = '0;
    x[4] = 1'b1;
    for (int i = 0; i < L - 5; i++) begin
      logic b;
      b = 1'b0;
      for (int k = 0; k < 5; k++) if (taps[k]) b = b ^ x[i+k];
      x[i+5] = b;
    end
    return x;
  endfunction

  function automatic logic [1:0] exp_beat(input int n, input int nid, input int a0,
                                          input int a1, input logic sf);
    logic [30:0] xs, xc, xz;
    logic s0, s1, c0, c1, z0, z1;
    xs = xseq(5'b00101);
    xc = xseq(5'b01001);
    xz = xseq(5'b10111);
    s0 = xs[5'((n + a0) % L)];
    s1 = xs[5'((n + a1) % L)];
    c0 = xc[5'((n + nid) % L)];
    c1 = xc[5'((n + nid + 3) % L)];
    z0 = xz[5'((n + a0 % 8) % L)];
    z1 = xz[5'((n + a1 % 8) % L)];
    return sf ? {s0 ^ c1 ^ z1, s1 ^ c0} : {s1 ^ c1 ^ z0, s0 ^ c0};
  endfunction

  task automatic launch(input int nid, input int a0, input int a1, input logic sf, input bit hold);
    n_id_2 = 2'(nid);
    m0 = 5'(a0);
    m1 = 5'(a1);
    subframe5 = sf;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  // Counts edges from the start-sampling edge to the first visible dout_valid
  task automatic wait_valid(input string tag);
    int edges = 0;
    int errs = 0;
    while (!sif.dout_valid && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (cfg_err) errs++;
    end
    chk({tag, "_latency"}, 32'(edges), L + 1);
    chk({tag, "_no_cfg_err"}, 32'(errs), 0);
  endtask

  task automatic run_beats(input string tag, input int nid, input int a0, input int a1,
                           input logic sf, input bit rnd, input int abort_at);
    int   n = 0;
    int   cyc = 0;
    logic rdy;
    while (n < L && cyc < 400) begin
      if (n == abort_at) begin
        abort = 1'b1;
        sif.dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk({tag, "_abort_busy"}, 32'(busy), 0);
        chk({tag, "_abort_valid"}, 32'(sif.dout_valid), 0);
        chk({tag, "_abort_dout"}, 32'(sif.dout), 0);
        chk({tag, "_abort_done"}, 32'(done), 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_abort_nodone"}, 32'(done), 0);
        return;
      end
      chk($sformatf("%s_valid%0d", tag, n), 32'(sif.dout_valid), 1);
      chk($sformatf("%s_beat%0d", tag, n), 32'(sif.dout), 32'(exp_beat(n, nid, a0, a1, sf)));
      chk($sformatf("%s_last%0d", tag, n), 32'(sif.dout_last), 32'(n == L - 1));
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sif.dout_ready = rdy;
      if (rdy) cap[n] = sif.dout;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rdy) n++;
    end
    sif.dout_ready = 1'b1;
    chk({tag, "_beats"}, 32'(n), L);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_valid_end"}, 32'(sif.dout_valid), 0);
    chk({tag, "_dout_end"}, 32'(sif.dout), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.dout_ready = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_dout", 32'(sif.dout), 0);
    chk("rst_valid", 32'(sif.dout_valid), 0);
    chk("rst_last", 32'(sif.dout_last), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Defaults, always ready; hand-derived beats 0/4/6
    launch(0, 0, 1, 1'b0, 1'b0);
    wait_valid("t1");
    run_beats("t1", 0, 0, 1, 1'b0, 1'b0, -1);
    @(posedge clk);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_hand_b0", 32'(cap[0]), 32'h0);
    chk("t1_hand_b4", 32'(cap[4]), 32'h2);
    chk("t1_hand_b6", 32'(cap[6]), 32'h3);

    // Subframe 5 mapping
    launch(0, 0, 1, 1'b1, 1'b0);
    wait_valid("t2");
    run_beats("t2", 0, 0, 1, 1'b1, 1'b0, -1);

    // Random ready; inputs and a bad start while busy must not disturb the job
    launch(2, 17, 29, 1'b0, 1'b0);
    n_id_2 = 2'd3;
    m0 = 5'd31;
    m1 = 5'd4;
    subframe5 = 1'b1;
    start = 1'b1;
    wait_valid("t3");
    start = 1'b0;
    run_beats("t3", 2, 17, 29, 1'b0, 1'b1, -1);

    // Rejected configurations
    n_id_2 = 2'd0;
    m0 = 5'd31;
    m1 = 5'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("t4_m0_cfg_err", 32'(cfg_err), 1);
    chk("t4_m0_busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_m0_cfg_err_pulse", 32'(cfg_err), 0);
    chk("t4_m0_valid", 32'(sif.dout_valid), 0);
    n_id_2 = 2'd3;
    m0 = 5'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("t4_nid_cfg_err", 32'(cfg_err), 1);
    chk("t4_nid_busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_nid_cfg_err_pulse", 32'(cfg_err), 0);
    n_id_2 = 2'd0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t4_abort_start_busy", 32'(busy), 0);
    chk("t4_abort_start_cfg_err", 32'(cfg_err), 0);

    // Abort on beat 10
    launch(0, 0, 1, 1'b0, 1'b0);
    wait_valid("t5");
    run_beats("t5", 0, 0, 1, 1'b0, 1'b0, 10);

    // Reset during GEN, then a fresh job
    launch(1, 7, 12, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_valid", 32'(sif.dout_valid), 0);
    chk("t6_rst_dout", 32'(sif.dout), 0);
    chk("t6_rst_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_done", 32'(done), 0);
    launch(0, 0, 1, 1'b0, 1'b0);
    wait_valid("t6");
    run_beats("t6", 0, 0, 1, 1'b0, 1'b0, -1);

    // Start held high: second job accepted in the done cycle
    launch(1, 5, 20, 1'b1, 1'b1);
    wait_valid("t7a");
    run_beats("t7a", 1, 5, 20, 1'b1, 1'b0, -1);
    @(posedge clk);
    @(negedge clk);
    chk("t7_b2b_busy", 32'(busy), 1);
    start = 1'b0;
    wait_valid("t7b");
    run_beats("t7b", 1, 5, 20, 1'b1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
